// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV64M multiply/divide unit: shift-add multiply, restoring divide, 64 iterations
// Define MDU_MULH_EN to build MULH/MULHSU/MULHU with a 128-bit product register.
module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            illegal
);
`ifdef MDU_MULH_EN
    localparam int   PW      = 2 * XLEN;
    localparam logic MULH_EN = 1'b1;
`else
    localparam int   PW      = XLEN;
    localparam logic MULH_EN = 1'b0;
`endif
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic            ill_q, sa_q, neg_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   a_q, acc_q;
    logic [XLEN-1:0] b_q, res_q;

    logic            mulh_in, dsgn_in, sa_in, sb_in, dzero_in, dovf_in, ill_in, fast_in, accept;
    logic [XLEN-1:0] a_abs, b_abs, fast_res;

    always_comb begin
        mulh_in  = !funct3[2] && (funct3[1:0] != 2'b00);
        dsgn_in  = funct3[2] && !funct3[0];
        sa_in    = op_a[XLEN-1] && (dsgn_in || funct3 == 3'b001 || funct3 == 3'b010);
        sb_in    = op_b[XLEN-1] && (dsgn_in || funct3 == 3'b001);
        a_abs    = sa_in ? -op_a : op_a;
        b_abs    = sb_in ? -op_b : op_b;
        dzero_in = funct3[2] && (op_b == '0);
        dovf_in  = dsgn_in && (op_a == SMIN) && (op_b == '1);
        ill_in   = mulh_in && !MULH_EN;
        fast_in  = dzero_in || dovf_in || ill_in;
        if (ill_in)
            fast_res = '0;
        else if (dzero_in)
            fast_res = funct3[1] ? op_a : '1;
        else
            fast_res = funct3[1] ? '0 : op_a;
        accept = (state_q == S_IDLE) && start && !kill;
    end

    // Divide keeps the dividend/quotient in a_q[XLEN-1:0] and the remainder in acc_q[XLEN-1:0].
    logic [PW-1:0]   acc_mul, prod;
    logic [XLEN:0]   rs;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_f, rem_f, fin_res;

    always_comb begin
        acc_mul = acc_q + (b_q[0] ? a_q : '0);
        rs      = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        ge      = rs >= {1'b0, b_q};
        rem_nx  = ge ? (rs[XLEN-1:0] - b_q) : rs[XLEN-1:0];
        quo_nx  = {a_q[XLEN-2:0], ge};
        prod    = neg_q ? -acc_mul : acc_mul;
        quo_f   = neg_q ? -quo_nx : quo_nx;
        rem_f   = sa_q ? -rem_nx : rem_nx;
        if (f3_q[2])
            fin_res = f3_q[1] ? rem_f : quo_f;
        else if (f3_q[1:0] != 2'b00)
            fin_res = prod[PW-1 -: XLEN];
        else
            fin_res = prod[XLEN-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast_in ? S_DONE : S_RUN;
            S_RUN: begin
                if (kill)
                    state_d = S_IDLE;
                else if (cnt_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q  <= '0;
            rd_q  <= '0;
            ill_q <= 1'b0;
            sa_q  <= 1'b0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            f3_q  <= funct3;
            rd_q  <= rd_in;
            ill_q <= ill_in;
            sa_q  <= sa_in;
            neg_q <= sa_in ^ sb_in;
            cnt_q <= '0;
            a_q   <= PW'(a_abs);
            b_q   <= b_abs;
            acc_q <= '0;
            if (fast_in)
                res_q <= fast_res;
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + CW'(1);
            if (f3_q[2]) begin
                a_q   <= PW'(quo_nx);
                acc_q <= PW'(rem_nx);
            end else begin
                a_q   <= a_q << 1;
                acc_q <= acc_mul;
                b_q   <= b_q >> 1;
            end
            if (cnt_q == LAST && !kill)
                res_q <= fin_res;
        end
    end

    assign result  = res_q;
    assign rd_out  = rd_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter: vector table, random ops vs arithmetic model, corner sequences
module tb_mdu_iter;
    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, illegal;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out), .illegal(illegal)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic ill, output int lat);
        logic ovf;
`ifdef MDU_MULH_EN
        logic [127:0] xa, xb, p;
`endif
        ovf = (a == SMIN) && (b == ONES);
        ill = 1'b0;
        lat = 64;
        r   = '0;
        case (f3)
            3'd0: r = a * b;
            3'd4: begin
                if (b == 64'd0) begin r = ONES; lat = 0; end
                else if (ovf) begin r = a; lat = 0; end
                else r = $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 64'd0) begin r = ONES; lat = 0; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 64'd0) begin r = a; lat = 0; end
                else if (ovf) begin r = 64'd0; lat = 0; end
                else r = $signed(a) % $signed(b);
            end
            3'd7: begin
                if (b == 64'd0) begin r = a; lat = 0; end
                else r = a % b;
            end
            default: begin
`ifdef MDU_MULH_EN
                xa = (f3 != 3'd3 && a[63]) ? {ONES, a} : {64'd0, a};
                xb = (f3 == 3'd1 && b[63]) ? {ONES, b} : {64'd0, b};
                p  = xa * xb;
                r  = p[127:64];
`else
                ill = 1'b1;
                lat = 0;
`endif
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < maxc) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] eres, input logic eill, input int elat);
        int l;
        issue(f3, a, b, rd);
        chk({name, " busy after accept"}, 64'(busy), 64'd1);
        wait_done(200, l);
        chk({name, " done latency"}, 64'(l), 64'(elat));
        chk({name, " result"}, result, eres);
        chk({name, " rd_out"}, 64'(rd_out), 64'(rd));
        chk({name, " illegal"}, 64'(illegal), 64'(eill));
        @(posedge clk);
        #1;
        chk({name, " busy after done"}, 64'(busy), 64'd0);
        chk({name, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1);
    end

    initial begin
        int l, seen;
        reset = 1'b1; start = 1'b0; kill = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

        vecs[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 64};
        vecs[1]  = '{3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64};
        vecs[2]  = '{3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64};
        vecs[3]  = '{3'd5, 64'd100, 64'd7, 5'd8, 64'd14, 1'b0, 64};
        vecs[4]  = '{3'd5, 64'h1234, 64'd0, 5'd9, ONES, 1'b0, 0};
        vecs[5]  = '{3'd6, SMIN, ONES, 5'd10, 64'd0, 1'b0, 0};
        vecs[6]  = '{3'd4, SMIN, ONES, 5'd11, SMIN, 1'b0, 0};
`ifdef MDU_MULH_EN
        vecs[7]  = '{3'd3, ONES, ONES, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64};
`else
        vecs[7]  = '{3'd3, ONES, ONES, 5'd12, 64'd0, 1'b1, 0};
`endif
        vecs[8]  = '{3'd7, 64'd5, 64'd0, 5'd13, 64'd5, 1'b0, 0};
        vecs[9]  = '{3'd5, 64'd9, 64'd3, 5'd14, 64'd3, 1'b0, 64};
        vecs[10] = '{3'd6, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA, 5'd15, 64'd2, 1'b0, 64};
        vecs[11] = '{3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd16, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64};

        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset rd_out", 64'(rd_out), 64'd0);
        chk("reset illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].res, vecs[i].ill, vecs[i].lat);

        // A start pulse while busy must not disturb the running DIVU or queue a second op
        issue(3'd5, 64'd100, 64'd7, 5'd9);
        repeat (10) begin @(posedge clk); #1; end
        funct3 = 3'd0; op_a = 64'd2; op_b = 64'd2; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200, l);
        chk("busy-start latency", 64'(l), 64'd53);
        chk("busy-start result", result, 64'd14);
        chk("busy-start rd_out", 64'(rd_out), 64'd9);
        count_done(70, seen);
        chk("busy-start no second done", 64'(seen), 64'd0);
        chk("busy-start idle", 64'(busy), 64'd0);

        issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7);
        repeat (29) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill busy", 64'(busy), 64'd0);
        count_done(80, seen);
        chk("kill no done", 64'(seen), 64'd0);
        run_op("after-kill divu", 3'd5, 64'd9, 64'd3, 5'd4, 64'd3, 1'b0, 64);

        issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5);
        repeat (20) begin @(posedge clk); #1; end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun reset busy", 64'(busy), 64'd0);
        chk("midrun reset done", 64'(done), 64'd0);
        chk("midrun reset result", result, 64'd0);
        chk("midrun reset rd_out", 64'(rd_out), 64'd0);
        chk("midrun reset illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(70, seen);
        chk("midrun reset no done", 64'(seen), 64'd0);
        run_op("after-reset divu", 3'd5, 64'd9, 64'd3, 5'd2, 64'd3, 1'b0, 64);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f3;
            logic [63:0] a, b, er;
            logic        ei;
            int          el;
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: begin a = SMIN; b = ONES; end
                2: begin a = 64'($urandom_range(0, 1000)); b = 64'($urandom_range(1, 50)); end
                3: b = 64'($urandom_range(1, 9));
                default: ;
            endcase
            model(f3, a, b, er, ei, el);
            run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, f3, a, b), f3, a, b, 5'(i), er, ei, el);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
